// File: rtl/pc_redirect_ctrl.sv
// PC redirect controller: arbitrates trap / mispredict / predictor redirects into a
// registered PC load plus instruction-ROM flush window, and paces outcome feedback.
package core_config_pkg;
   parameter int XLEN = 32;
endpackage

module pc_redirect_ctrl #(
   parameter int              XLEN         = core_config_pkg::XLEN,
   parameter int              FLUSH_CYCLES = 2,
   parameter logic [XLEN-1:0] RESET_ADDR   = '0
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            trap_req,
   input  logic [XLEN-1:0] trap_addr,
   input  logic            exe_valid,
   input  logic            exe_taken,
   input  logic            exe_predicted,
   input  logic [XLEN-1:0] exe_target,
   input  logic [XLEN-1:0] exe_fallthrough,
   input  logic            bpu_write,
   input  logic [XLEN-1:0] bpu_addr,
   output logic            exe_ready,
   output logic [XLEN-1:0] PC_value,
   output logic            PC_write,
   output logic            rom_flush,
   output logic            stall,
   output logic            predict_ok,
   output logic            mispredict
);

   typedef enum logic [1:0] {S_IDLE, S_REDIRECT, S_FLUSH} state_t;

   localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

   state_t          r_state;
   logic [3:0]      r_cnt;
   logic [XLEN-1:0] r_pc_value;
   logic            r_pc_write;
   logic            r_rom_flush;
   logic            r_stall;
   logic            r_ok;
   logic            r_mis;
   logic            r_pend_vld;
   logic            r_pend_mis;

   logic            w_acc;
   logic            w_wrong;
   logic            w_mis;
   logic            w_redir;
   logic [XLEN-1:0] w_addr;

   assign w_acc   = exe_valid & ~r_pend_vld;
   assign w_wrong = exe_taken != exe_predicted;
   assign w_mis   = w_acc & w_wrong;
   // Predictor redirects only win an otherwise quiet IDLE cycle; losers are dropped.
   assign w_redir = trap_req | w_mis | (bpu_write & (r_state == S_IDLE));
   assign w_addr  = trap_req ? trap_addr :
                    w_mis    ? (exe_taken ? exe_target : exe_fallthrough) :
                               bpu_addr;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         r_pc_value  <= RESET_ADDR;
         r_pc_write  <= 1'b0;
         r_rom_flush <= 1'b1;
         r_stall     <= 1'b0;
      end else if (w_redir) begin
         r_state     <= S_REDIRECT;
         r_cnt       <= FLUSH_LOAD;
         r_pc_value  <= w_addr;
         r_pc_write  <= 1'b1;
         r_rom_flush <= 1'b0;
         r_stall     <= 1'b1;
      end else begin
         case (r_state)
            S_REDIRECT: begin
               r_state    <= S_FLUSH;
               r_pc_write <= 1'b0;
            end
            S_FLUSH: begin
               if (r_cnt == '0) begin
                  r_state     <= S_IDLE;
                  r_rom_flush <= 1'b1;
                  r_stall     <= 1'b0;
               end else begin
                  r_cnt <= r_cnt - 4'd1;
               end
            end
            default: begin
               r_state     <= S_IDLE;
               r_pc_write  <= 1'b0;
               r_rom_flush <= 1'b1;
               r_stall     <= 1'b0;
            end
         endcase
      end
   end

   // Outcome pulses: one high cycle then a mandatory low cycle; one-deep overflow.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_ok       <= 1'b0;
         r_mis      <= 1'b0;
         r_pend_vld <= 1'b0;
         r_pend_mis <= 1'b0;
      end else if (r_ok | r_mis) begin
         r_ok  <= 1'b0;
         r_mis <= 1'b0;
         if (w_acc) begin
            r_pend_vld <= 1'b1;
            r_pend_mis <= w_wrong;
         end
      end else if (r_pend_vld) begin
         r_ok       <= ~r_pend_mis;
         r_mis      <= r_pend_mis;
         r_pend_vld <= 1'b0;
      end else if (w_acc) begin
         r_ok  <= ~w_wrong;
         r_mis <= w_wrong;
      end
   end

   assign exe_ready  = ~r_pend_vld;
   assign PC_value   = r_pc_value;
   assign PC_write   = r_pc_write;
   assign rom_flush  = r_rom_flush;
   assign stall      = r_stall;
   assign predict_ok = r_ok;
   assign mispredict = r_mis;

endmodule

// File: doc/pc_redirect_ctrl.md
PC_REDIRECT_CTRL -- requirements
Module: pc_redirect_ctrl

Interface
REQ-001 SHALL have parameter XLEN, default core_config_pkg::XLEN (32), address width.
REQ-002 SHALL have parameter FLUSH_CYCLES, default 2, number of cycles rom_flush stays low after a redirect write (range 1..15).
REQ-003 SHALL have parameter RESET_ADDR, default 32'h0000_0000, PC_value driven while in reset.
REQ-004 SHALL have port clk  input  1  single rising-edge clock.
REQ-005 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port trap_req  input  1  trap/exception redirect request, highest priority.
REQ-007 SHALL have port trap_addr  input  XLEN  trap handler address.
REQ-008 SHALL have port exe_valid  input  1  branch resolved in execute this cycle.
REQ-009 SHALL have port exe_taken  input  1  actual branch outcome.
REQ-010 SHALL have port exe_predicted  input  1  outcome predicted at fetch.
REQ-011 SHALL have port exe_target  input  XLEN  taken target.
REQ-012 SHALL have port exe_fallthrough  input  XLEN  not-taken address (branch PC + 4).
REQ-013 SHALL have port bpu_write  input  1  predictor redirect request, lowest priority.
REQ-014 SHALL have port bpu_addr  input  XLEN  predicted target.
REQ-015 SHALL have port exe_ready  output  1  high when exe_valid is accepted this cycle.
REQ-016 SHALL have port PC_value  output  XLEN  redirect address to PC register.
REQ-017 SHALL have port PC_write  output  1  one-cycle PC load strobe.
REQ-018 SHALL have port rom_flush  output  1  instruction-ROM flush, active-low (0 = flush).
REQ-019 SHALL have port stall  output  1  fetch stall, high whenever FSM not IDLE.
REQ-020 SHALL have ports predict_ok / mispredict  output  1 each  outcome feedback pulses to predictor.

Function
REQ-021 SHALL implement FSM IDLE -> REDIRECT (1 cycle) -> FLUSH (FLUSH_CYCLES cycles, down-counter) -> IDLE; all outputs registered.
REQ-022 SHALL, for a request sampled at edge N, drive PC_write=1, PC_value=address, rom_flush=0 during cycle N+1 (REDIRECT state).
REQ-023 SHALL hold rom_flush=0, PC_write=0, stall=1 during FLUSH; rom_flush returns to 1 on the IDLE cycle.
REQ-024 SHALL compute exe_mis = exe_valid & exe_ready & (exe_taken != exe_predicted); redirect address = exe_taken ? exe_target : exe_fallthrough.
REQ-025 SHALL arbitrate per cycle: trap_req > exe_mis > bpu_write; losers are dropped, not queued.
REQ-026 SHALL accept trap_req and exe_mis in any state: from REDIRECT/FLUSH they restart REDIRECT with the new address and reload the flush counter.
REQ-027 SHALL ignore bpu_write unless state is IDLE and no trap_req/exe_mis in the same cycle.
REQ-028 SHALL report every accepted exe_valid as exactly one pulse: mispredict if exe_mis, else predict_ok; never both high.
REQ-029 SHALL drive each outcome pulse high for exactly one cycle followed by at least one cycle with both low (predictor acks on level).
REQ-030 SHALL hold an outcome arriving while a pulse is high in a one-deep pending register and issue it after the mandatory low cycle.
REQ-031 SHALL drive exe_ready = !pending_valid; exe_valid with exe_ready=0 is ignored for both outcome and redirect.
REQ-032 SHALL generate outcome feedback independently of redirect arbitration (a trap beating a mispredict still yields the mispredict pulse).

Reset
REQ-033 SHALL, while rst_n=0 at a rising edge, force state IDLE, counter 0, pending empty, PC_value=RESET_ADDR, PC_write=0, rom_flush=1, stall=0, predict_ok=0, mispredict=0, exe_ready=1.
REQ-034 SHALL abort any in-progress REDIRECT/FLUSH or pending outcome on reset with no further PC_write.

Verification
REQ-035 SHALL check: bpu_write=1, bpu_addr=0x100 in IDLE -> next cycle PC_write=1, PC_value=0x100, rom_flush=0; rom_flush=0 two more cycles; IDLE after.
REQ-036 SHALL check: exe_valid, taken=0, predicted=1, fallthrough=0x204 with bpu_write same cycle -> PC_value=0x204, mispredict one-cycle pulse, bpu dropped.
REQ-037 SHALL check: trap_req addr=0x80 on first FLUSH cycle of a prior redirect -> REDIRECT restarts, PC_value=0x80, flush counter reloaded (2 cycles).
REQ-038 SHALL check: exe_valid correct predictions on 3 consecutive cycles -> predict_ok pulses separated by low cycles, exe_ready=0 while pending full, third held until ready.
REQ-039 SHALL check: rst_n=0 during FLUSH -> next edge rom_flush=1, stall=0, PC_write=0, PC_value=RESET_ADDR.
